// File: rtl/ecc_mod_pkg.sv
// -----------------------------------------------------------------------------
// ecc_mod_pkg
// Shared definitions for the limb-serial modular arithmetic blocks of the ECC
// field datapath: default operand/limb widths, the limb-count derivation and
// the IDLE/CALC/DONE sequencing encoding used by the serial mod add/sub units.
// No ports (package).
// -----------------------------------------------------------------------------
package ecc_mod_pkg;

    // Default field operand width and per-cycle limb width.
    localparam int unsigned ECC_DATA_WIDTH = 256;
    localparam int unsigned ECC_LIMB_WIDTH = 64;

    // Number of limbs an operand splits into; data_width must be a multiple of limb_width.
    function automatic int unsigned ecc_num_limbs(input int unsigned data_width,
                                                  input int unsigned limb_width);
        return data_width / limb_width;
    endfunction

    localparam int unsigned ECC_NUM_LIMBS = ecc_num_limbs(ECC_DATA_WIDTH, ECC_LIMB_WIDTH);

    // Sequencing states shared by the serial modular units.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mod_state_t;

endpackage : ecc_mod_pkg

// File: rtl/add_mod_serial_if.sv
// -----------------------------------------------------------------------------
// add_mod_serial_if
// Operand/result handshake bundle for the serial modular adder.
// Signals:
//   in_valid  : producer has operands            (master -> slave)
//   in_ready  : block can accept operands        (slave  -> master)
//   opA, opB  : addends, each < opM              (master -> slave)
//   opM       : modulus, nonzero                 (master -> slave)
//   out_valid : result valid                     (slave  -> master)
//   out_ready : consumer accepts result          (master -> slave)
//   out_data  : (opA + opB) mod opM              (slave  -> master)
// -----------------------------------------------------------------------------
interface add_mod_serial_if
    import ecc_mod_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ECC_DATA_WIDTH
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] opA;
    logic [DATA_WIDTH-1:0] opB;
    logic [DATA_WIDTH-1:0] opM;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    // Requester side: supplies operands, consumes results.
    modport master (
        output in_valid,
        output opA,
        output opB,
        output opM,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Adder side.
    modport slave (
        input  in_valid,
        input  opA,
        input  opB,
        input  opM,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface : add_mod_serial_if

// File: rtl/limb_add_sub.sv
// -----------------------------------------------------------------------------
// limb_add_sub
// One limb of the serial modular adder datapath (combinational). Adds two limbs
// with carry-in, then subtracts the modulus limb with borrow-in from the
// truncated sum, so the add and reduce chains advance in the same cycle.
// Ports:
//   i_a, i_b : addend limbs
//   i_m      : modulus limb
//   i_cin    : carry in from the previous (lower) limb
//   i_bin    : borrow in from the previous (lower) limb
//   o_s      : low LIMB_WIDTH bits of i_a + i_b + i_cin
//   o_cout   : carry out of the sum
//   o_d      : low LIMB_WIDTH bits of o_s - i_m - i_bin
//   o_bout   : borrow out of the difference
// -----------------------------------------------------------------------------
module limb_add_sub #(
    parameter int unsigned LIMB_WIDTH = 64
) (
    input  logic [LIMB_WIDTH-1:0] i_a,
    input  logic [LIMB_WIDTH-1:0] i_b,
    input  logic [LIMB_WIDTH-1:0] i_m,
    input  logic                  i_cin,
    input  logic                  i_bin,
    output logic [LIMB_WIDTH-1:0] o_s,
    output logic                  o_cout,
    output logic [LIMB_WIDTH-1:0] o_d,
    output logic                  o_bout
);

    localparam int unsigned EXT_W = LIMB_WIDTH + 1;

    logic [EXT_W-1:0] w_sum;
    logic [EXT_W-1:0] w_diff;

    // One extra bit on each chain captures carry/borrow out.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + EXT_W'(i_cin);
    // Borrow shows up as bit LIMB_WIDTH going high when the result is negative.
    assign w_diff = {1'b0, w_sum[LIMB_WIDTH-1:0]} - {1'b0, i_m} - EXT_W'(i_bin);

    assign o_s    = w_sum[LIMB_WIDTH-1:0];
    assign o_cout = w_sum[LIMB_WIDTH];
    assign o_d    = w_diff[LIMB_WIDTH-1:0];
    assign o_bout = w_diff[LIMB_WIDTH];

endmodule : limb_add_sub

// File: rtl/add_mod_serial.sv
// -----------------------------------------------------------------------------
// add_mod_serial
// Multi-cycle modular adder: out_data = (opA + opB) mod opM, processed one
// limb per cycle, least significant limb first. Sum and sum-minus-modulus are
// built side by side; one extra cycle after the last limb picks the reduced
// or unreduced value into the output register.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : operand/result handshake (slave side)
//           in_valid/in_ready/opA/opB/opM in, out_valid/out_ready/out_data out
// Timing: out_valid rises NUM_LIMBS+1 edges after the accepting edge and holds
// with stable out_data until out_ready; no overlap between operations.
// -----------------------------------------------------------------------------
module add_mod_serial
    import ecc_mod_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ECC_DATA_WIDTH,
    parameter int unsigned LIMB_WIDTH = ECC_LIMB_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    add_mod_serial_if.slave bus
);

    localparam int unsigned NUM_LIMBS = ecc_num_limbs(DATA_WIDTH, LIMB_WIDTH);
    // idx runs 0..NUM_LIMBS; the value NUM_LIMBS marks the select cycle.
    localparam int unsigned IDX_W     = $clog2(NUM_LIMBS + 1);

    mod_state_t            r_state;
    mod_state_t            w_state_nxt;
    logic [IDX_W-1:0]      r_idx;

    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_m;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_diff;
    logic                  r_c;
    logic                  r_br;

    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  w_in_ready_nxt;
    logic                  w_out_valid_nxt;

    logic                  w_accept;
    logic                  w_limb_step;
    logic                  w_finish;
    logic                  w_out_hs;

    logic [LIMB_WIDTH-1:0] w_limb_s;
    logic [LIMB_WIDTH-1:0] w_limb_d;
    logic                  w_cout;
    logic                  w_bout;

    assign w_accept    = r_in_ready & bus.in_valid;
    assign w_limb_step = (r_state == ST_CALC) && (r_idx < IDX_W'(NUM_LIMBS));
    assign w_finish    = (r_state == ST_CALC) && (r_idx == IDX_W'(NUM_LIMBS));
    assign w_out_hs    = r_out_valid & bus.out_ready;

    // Current low limb of each operand shift register feeds the limb slice.
    limb_add_sub #(
        .LIMB_WIDTH (LIMB_WIDTH)
    ) u_limb (
        .i_a    (r_a[LIMB_WIDTH-1:0]),
        .i_b    (r_b[LIMB_WIDTH-1:0]),
        .i_m    (r_m[LIMB_WIDTH-1:0]),
        .i_cin  (r_c),
        .i_bin  (r_br),
        .o_s    (w_limb_s),
        .o_cout (w_cout),
        .o_d    (w_limb_d),
        .o_bout (w_bout)
    );

    // State and handshake output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
            ST_CALC: if (w_finish) w_state_nxt = ST_DONE;
            ST_DONE: if (w_out_hs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs follow the state being entered so they stay registered.
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        unique case (w_state_nxt)
            ST_IDLE: w_in_ready_nxt  = 1'b1;
            ST_DONE: w_out_valid_nxt = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, limb-serial accumulate and final select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_c        <= 1'b0;
            r_br       <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_m        <= '0;
            r_sum      <= '0;
            r_diff     <= '0;
            r_out_data <= '0;
        end else if (w_accept) begin
            r_a   <= bus.opA;
            r_b   <= bus.opB;
            r_m   <= bus.opM;
            r_c   <= 1'b0;
            r_br  <= 1'b0;
            r_idx <= '0;
        end else if (w_limb_step) begin
            r_a    <= r_a >> LIMB_WIDTH;
            r_b    <= r_b >> LIMB_WIDTH;
            r_m    <= r_m >> LIMB_WIDTH;
            // New limb enters at the top; after NUM_LIMBS steps limb 0 sits at the bottom.
            r_sum  <= DATA_WIDTH'({w_limb_s, r_sum} >> LIMB_WIDTH);
            r_diff <= DATA_WIDTH'({w_limb_d, r_diff} >> LIMB_WIDTH);
            r_c    <= w_cout;
            r_br   <= w_bout;
            r_idx  <= r_idx + IDX_W'(1);
        end else if (w_finish) begin
            // A final carry or no final borrow both mean sum >= opM.
            r_out_data <= (r_c || !r_br) ? r_diff : r_sum;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule : add_mod_serial

// File: tb/tb_add_mod_serial.sv
// -----------------------------------------------------------------------------
// tb_add_mod_serial
// Scoreboard bench for add_mod_serial: the driver pushes the expected result
// of every accepted operation, the monitor pops and compares on each output
// handshake and also checks latency and that in_ready stays low while busy.
// -----------------------------------------------------------------------------
module tb_add_mod_serial;
    import ecc_mod_pkg::*;

    localparam int unsigned DW      = ECC_DATA_WIDTH;
    localparam int          LATENCY = int'(ECC_NUM_LIMBS) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_mod_serial_if #(.DATA_WIDTH(DW)) bus_if ();

    add_mod_serial u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // out_ready is either held by the main sequence or randomly toggled.
    logic hold_ready = 1'b1;
    logic rnd_bp     = 1'b0;
    logic rnd_ready  = 1'b1;
    assign bus_if.out_ready = rnd_bp ? rnd_ready : hold_ready;

    initial forever begin
        @(posedge clk);
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Reference: plain wide addition followed by at most one subtraction of m.
    function automatic logic [DW-1:0] ref_mod_add(input logic [DW-1:0] a, b, m);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and register its expected result.
    task automatic do_op(input logic [DW-1:0] a, b, m, e);
        int n;
        n = 0;
        while (!bus_if.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus_if.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 required 1");
            return;
        end
        bus_if.in_valid = 1'b1;
        bus_if.opA      = a;
        bus_if.opB      = b;
        bus_if.opM      = m;
        exp_q.push_back(e);
        tick();
        // Scramble operands after acceptance; they must have no effect.
        bus_if.in_valid = 1'b0;
        bus_if.opA      = rand256();
        bus_if.opB      = rand256();
        bus_if.opM      = rand256();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: pending got %0d required 0", exp_q.size());
        end
    endtask

    // Monitor: latency, busy in_ready, and scoreboard pop on output handshake.
    int cyc      = 0;
    int acc_edge = 0;
    bit prev_ov  = 1'b0;
    bit busy     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [DW-1:0] e;
        if (rst_n) begin
            if (busy) check("in_ready_busy", DW'(bus_if.in_ready), '0);
            if (bus_if.out_valid && !prev_ov)
                check("latency", DW'(cyc - acc_edge), DW'(LATENCY));
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h required no output", bus_if.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus_if.out_data, e);
                end
                busy = 1'b0;
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                busy     = 1'b1;
                acc_edge = cyc + 1;
            end
            prev_ov = bus_if.out_valid;
        end else begin
            busy    = 1'b0;
            prev_ov = 1'b0;
        end
    end

    initial begin
        logic [DW-1:0] a, b, m, big_m, one_limb, p2_255, p2_64;
        int n;

        bus_if.in_valid = 1'b0;
        bus_if.opA      = '0;
        bus_if.opB      = '0;
        bus_if.opM      = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  DW'(bus_if.in_ready),  DW'(1));
        check("rst_out_valid", DW'(bus_if.out_valid), '0);
        check("rst_out_data",  bus_if.out_data,       '0);
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        do_op(DW'(3), DW'(4), DW'(11), DW'(7));
        do_op(DW'(5), DW'(7), DW'(11), DW'(1));
        do_op(DW'(6), DW'(5), DW'(11), DW'(0));
        one_limb = '0;
        one_limb[63:0] = '1;
        p2_255 = '0;
        p2_255[255] = 1'b1;
        p2_64 = '0;
        p2_64[64] = 1'b1;
        do_op(one_limb, DW'(1), p2_255, p2_64);
        big_m = '1;
        big_m = big_m - DW'(188);
        do_op(big_m - DW'(1), big_m - DW'(1), big_m, big_m - DW'(2));
        drain();

        // Backpressure: result held, new in_valid ignored, then back-to-back accept
        hold_ready = 1'b0;
        do_op(DW'(10), DW'(20), DW'(23), DW'(7));
        n = 0;
        while (!bus_if.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_valid_seen", DW'(bus_if.out_valid), DW'(1));
        for (int k = 0; k < 6; k++) begin
            check("bp_valid",    DW'(bus_if.out_valid), DW'(1));
            check("bp_data",     bus_if.out_data,       DW'(7));
            check("bp_in_ready", DW'(bus_if.in_ready),  '0);
            if (k == 1) begin
                bus_if.in_valid = 1'b1;
                bus_if.opA      = DW'(1);
                bus_if.opB      = DW'(2);
                bus_if.opM      = DW'(5);
            end
            if (k == 3) bus_if.in_valid = 1'b0;
            tick();
        end
        hold_ready = 1'b1;
        tick();
        check("b2b_in_ready", DW'(bus_if.in_ready), DW'(1));
        do_op(DW'(8), DW'(9), DW'(13), DW'(4));
        drain();

        // Reset during the second CALC cycle aborts the operation
        do_op(DW'(3), DW'(4), DW'(11), DW'(7));
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("abort_out_valid", DW'(bus_if.out_valid), '0);
        check("abort_out_data",  bus_if.out_data,       '0);
        check("abort_in_ready",  DW'(bus_if.in_ready),  DW'(1));
        rst_n = 1'b1;
        do_op(DW'(3), DW'(4), DW'(11), DW'(7));
        drain();

        // Randomized in-contract operations under random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m = rand256() >> $urandom_range(0, 200);
            if (m == '0) m = DW'(1);
            a = rand256() % m;
            b = rand256() % m;
            do_op(a, b, m, ref_mod_add(a, b, m));
        end
        // Out-of-contract operands: only one conditional subtraction applies
        for (int i = 0; i < 8; i++) begin
            m = rand256() >> $urandom_range(1, 200);
            if (m == '0) m = DW'(3);
            a = rand256();
            b = rand256() >> $urandom_range(0, 255);
            do_op(a, b, m, ref_mod_add(a, b, m));
        end
        drain();
        rnd_bp = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_add_mod_serial
